rst_pack: RTL and testbench
===========================

Name: rst_pack

Overview:
- Downstream stage for the 4-bit valid/data stream produced by the reset-test datapath.
- Packs consecutive 4-bit nibbles into wide words and queues them in a small show-ahead FIFO.
- Presents the words on a valid/ready output interface.
- The input side has no backpressure, so FIFO overflow is detected and flagged rather than stalled.

Parameters:
- NIBBLES, 4, nibbles per output word; word width W = 4*NIBBLES; legal range 2..8.
- DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_i  input  1  nibble strobe; no ready returned.
- data_i  input  4  nibble, sampled when valid_i=1.
- flush_i  input  1  emit the current partial word.
- ready_i  input  1  downstream accepts the head word.
- valid_o  output  1  FIFO non-empty.
- data_o  output  W  head word; forced to 0 when valid_o=0.
- len_o  output  4  number of valid nibbles in the head word, 1..NIBBLES; 0 when empty.
- level_o  output  clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  output  1  sticky drop flag.

Behaviour:
- Reset: rst=0 asynchronously clears all state.
  - Outputs: valid_o=0, data_o=0, len_o=0, level_o=0, overflow_o=0.
  - Internal state: nibble index idx=0, partial word=0, FIFO pointers=0.
  - Reset mid-word discards the partial word. Reset mid-drain discards all queued words.
- Packing:
  - The nibble at index idx lands in bits [4*idx+3:4*idx], so the first nibble goes to the LSBs.
  - idx increments on each valid_i and wraps at NIBBLES.
- Push on the edge where valid_i=1 and idx=NIBBLES-1:
  - The completed word, including this nibble, is pushed with len=NIBBLES.
  - idx returns to 0 and the partial register clears.
- Flush:
  - flush_i=1, valid_i=0, idx>0: push the partial word with unfilled nibbles 0 and len=idx; idx goes to 0.
  - flush_i=1, valid_i=0, idx=0: no-op.
  - flush_i=1 with valid_i=1: the nibble is included first.
    - If that completes the word, exactly one push with len=NIBBLES.
    - Otherwise push with len=idx+1.
    - Never an extra empty word.
- Latency: a pushed word is visible on valid_o/data_o/len_o on the cycle after the push edge (1 cycle).
- FIFO:
  - Show-ahead; pop on an edge where valid_o=1 and ready_i=1.
  - Words emerge strictly in push order.
- Full boundary:
  - A push is accepted if level<DEPTH, or if a pop occurs on the same edge. In the pop case, level is unchanged.
  - Otherwise the word is dropped and overflow_o is set. The packer still resets idx to 0, so later words stay nibble-aligned.
  - overflow_o clears only on reset.
- Simultaneous push and pop when not full: level unchanged.
- Empty: a pop is impossible because valid_o=0; ready_i is ignored.
- Pointers wrap modulo DEPTH; level_o ranges 0..DEPTH.

Optional Feature:
- Macro: RST_PACK_PARITY_EN.
- When defined:
  - Adds output port parity_o (1 bit), the even parity of the head word: XOR of all bits of data_o and len_o.
  - parity_o is stored per FIFO entry at push time and is 0 when empty or in reset.
- When undefined: the port and its storage do not exist; all other behaviour is identical.

Test Plan:
- Defaults. Reset, ready_i=1, nibbles 1,2,3,4 on consecutive cycles -> cycle after 4th: valid_o=1, data_o=16'h4321, len_o=4, level_o=1; next cycle level_o=0, valid_o=0.
- Nibbles A, B then flush_i=1 alone -> data_o=16'h00BA, len_o=2; following nibbles C,D,E,F -> data_o=16'hFEDC, len_o=4.
- ready_i=0, 20 nibbles 0..F,0..3 -> level_o=4, overflow_o=1 after 5th word. Raising ready_i drains 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, then valid_o=0; overflow_o stays 1.
- FIFO full (level 4), ready_i=1 on the same edge as the 4th nibble of a new word -> word accepted, level_o stays 4, overflow_o=0.
- flush_i=1 together with the 4th nibble -> exactly one word with len_o=4 and no zero-length word. flush_i=1 with idx=0 -> level_o unchanged.
- Pull rst low mid-word (idx=2) with level_o=3 -> outputs 0 immediately without waiting for clk. After release, nibbles 5,6,7,8 yield 16'h8765.

Source files
------------

// File: rtl/rst_pack.sv
// -----------------------------------------------------------------------------
// rst_pack
// Collects the 4-bit valid/data stream from the reset-test datapath into wide
// words. Completed or flushed words are queued in a small show-ahead FIFO and
// presented on a valid/ready output interface.
//
// The input side cannot be stalled. When a word arrives and the FIFO has no
// room for it, the word is dropped and a sticky overflow flag is raised.
//
// Parameters
//   NIBBLES : nibbles per output word (2..8); word width W = 4*NIBBLES
//   DEPTH   : FIFO entries (power of 2, >= 2)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   valid_i    in   nibble strobe (no ready is returned)
//   data_i     in   4-bit nibble, sampled when valid_i=1
//   flush_i    in   emit the current partial word
//   ready_i    in   downstream accepts the head word
//   valid_o    out  FIFO non-empty
//   data_o     out  head word, 0 when empty
//   len_o      out  valid nibbles in the head word (1..NIBBLES), 0 when empty
//   level_o    out  FIFO occupancy (0..DEPTH)
//   overflow_o out  sticky flag: a word was dropped on a full FIFO
//   parity_o   out  (only with RST_PACK_PARITY_EN) XOR of all bits of the
//                   head data_o and len_o, 0 when empty
//
// Build option: define RST_PACK_PARITY_EN to add parity_o and its per-entry
// storage.
//
// Handshake: a word leaves the FIFO on a rising edge where valid_o=1 and
// ready_i=1. valid_o does not depend on ready_i. data_o and len_o hold steady
// while valid_o=1 and ready_i=0.
// -----------------------------------------------------------------------------
module rst_pack #(
  parameter  int NIBBLES = 4,
  parameter  int DEPTH   = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [3:0]    data_i,
  input  logic          flush_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [3:0]    len_o,
  output logic [LW-1:0] level_o,
`ifdef RST_PACK_PARITY_EN
  output logic          overflow_o,
  output logic          parity_o
`else
  output logic          overflow_o
`endif
);

  localparam int IW = $clog2(NIBBLES);
  localparam int PW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Packer state
  // ---------------------------------------------------------------------------
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [W-1:0]  partial;
  logic [W-1:0]  partial_nxt;
  logic [W-1:0]  merged;      // partial word with this cycle's nibble inserted
  logic [W-1:0]  push_word;
  logic [3:0]    push_len;
  logic          push;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [W-1:0]  data_mem [DEPTH];
  logic [3:0]    len_mem  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overflow;
  logic          pop;
  logic          accept;
  logic          full;
  logic          not_empty;

`ifdef RST_PACK_PARITY_EN
  logic          par_mem [DEPTH];
  logic          push_par;
`endif

  // ---------------------------------------------------------------------------
  // Packing / push decision
  // ---------------------------------------------------------------------------
  always_comb begin
    merged = partial;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        merged[4*i +: 4] = data_i;
      end
    end
  end

  always_comb begin
    push        = 1'b0;
    push_len    = 4'd0;
    push_word   = partial;
    idx_nxt     = idx;
    partial_nxt = partial;

    if (valid_i) begin
      // The nibble is always absorbed first. A completed word and a flush on
      // the same edge therefore produce exactly one push.
      push_word = merged;
      if (idx == LAST_IDX || flush_i) begin
        push        = 1'b1;
        push_len    = 4'(idx) + 4'd1;
        idx_nxt     = '0;
        partial_nxt = '0;
      end else begin
        idx_nxt     = idx + IW'(1);
        partial_nxt = merged;
      end
    end else if (flush_i && idx != '0) begin
      push        = 1'b1;
      push_len    = 4'(idx);
      idx_nxt     = '0;
      partial_nxt = '0;
    end
  end

`ifdef RST_PACK_PARITY_EN
  assign push_par = ^{push_word, push_len};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      partial <= '0;
    end else begin
      // The packer restarts even when the word is dropped, so later words
      // stay nibble-aligned.
      idx     <= idx_nxt;
      partial <= partial_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign not_empty = (level != '0);
  assign full      = (level == FULL_LVL);
  assign pop       = not_empty & ready_i;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign accept    = push & (~full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  // The storage array is not reset. Its contents are only observed through
  // occupied entries, and the outputs are forced to zero when the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_mem[wr_ptr] <= push_word;
      len_mem[wr_ptr]  <= push_len;
`ifdef RST_PACK_PARITY_EN
      par_mem[wr_ptr]  <= push_par;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign valid_o    = not_empty;
  assign data_o     = not_empty ? data_mem[rd_ptr] : '0;
  assign len_o      = not_empty ? len_mem[rd_ptr]  : 4'd0;
  assign level_o    = level;
  assign overflow_o = overflow;
`ifdef RST_PACK_PARITY_EN
  assign parity_o   = not_empty ? par_mem[rd_ptr] : 1'b0;
`endif

endmodule

// File: tb/tb_rst_pack.sv
// -----------------------------------------------------------------------------
// tb_rst_pack
// Self-checking bench for rst_pack (NIBBLES=4, DEPTH=4).
//
// The reference model works at the level of whole transactions. Pending
// nibbles are kept in a queue. A word is formed arithmetically when the word
// completes or is flushed. Queued words sit in exp_q/len_q and are compared
// against the DUT outputs after every clock edge.
//
// If RST_PACK_PARITY_EN is defined, parity_o is connected and checked as well.
// -----------------------------------------------------------------------------
module tb_rst_pack;

  localparam int NIBBLES = 4;
  localparam int DEPTH   = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int LW      = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic [3:0]    data_i = 4'd0;
  logic          flush_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          valid_o;
  logic [W-1:0]  data_o;
  logic [3:0]    len_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
`ifdef RST_PACK_PARITY_EN
  logic          parity_o;
`endif

  always #5 clk = ~clk;

  rst_pack #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .flush_i    (flush_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .len_o      (len_o),
    .level_o    (level_o),
`ifdef RST_PACK_PARITY_EN
    .overflow_o (overflow_o),
    .parity_o   (parity_o)
`else
    .overflow_o (overflow_o)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  logic [3:0]   len_q[$];
  logic [3:0]   pend_q[$];
  logic         m_ovf;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    len_q.delete();
    pend_q.delete();
    m_ovf = 1'b0;
  endtask

  // One clock edge's worth of transactions, using the inputs present at the edge.
  task automatic model_step(input logic v, input logic [3:0] d, input logic f, input logic r);
    logic          do_push;
    logic          do_pop;
    logic [W-1:0]  word;
    int            n;
    do_push = 1'b0;
    word    = '0;
    n       = 0;
    if (v) pend_q.push_back(d);
    if (pend_q.size() == NIBBLES || (f && pend_q.size() > 0)) begin
      n = pend_q.size();
      for (int k = 0; k < n; k++) word = word | (W'(pend_q[k]) << (4 * k));
      pend_q.delete();
      do_push = 1'b1;
    end
    do_pop = (exp_q.size() > 0) && r;
    if (do_push && !(exp_q.size() < DEPTH || do_pop)) begin
      m_ovf   = 1'b1;
      do_push = 1'b0;
    end
    if (do_pop) begin
      void'(exp_q.pop_front());
      void'(len_q.pop_front());
    end
    if (do_push) begin
      exp_q.push_back(word);
      len_q.push_back(4'(n));
    end
  endtask

  task automatic compare_all();
    logic          e_valid;
    logic [W-1:0]  e_data;
    logic [3:0]    e_len;
    e_valid = exp_q.size() > 0;
    e_data  = e_valid ? exp_q[0] : '0;
    e_len   = e_valid ? len_q[0] : 4'd0;
    chk("valid_o", 32'(valid_o), 32'(e_valid));
    chk("data_o", 32'(data_o), 32'(e_data));
    chk("len_o", 32'(len_o), 32'(e_len));
    chk("level_o", 32'(level_o), 32'(exp_q.size()));
    chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
`ifdef RST_PACK_PARITY_EN
    chk("parity_o", 32'(parity_o), 32'(e_valid ? ^{e_data, e_len} : 1'b0));
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic v, input logic [3:0] d, input logic f, input logic r);
    valid_i = v;
    data_i  = d;
    flush_i = f;
    ready_i = r;
    @(posedge clk);
    model_step(v, d, f, r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         v;
    logic [3:0]   d;
    logic         f;
    logic         r;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic [3:0]   e_len;
    logic [LW-1:0] e_level;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [W-1:0] drain_exp[4];

    model_clear();
    // Each entry gives the inputs and the outputs expected after that edge.
    tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[3]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 16'h4321, 4'd4, 3'd1, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[6]  = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h00BA, 4'd2, 3'd1, 1'b0};
    tbl[8]  = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[9]  = '{1'b1, 4'hD, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[10] = '{1'b1, 4'hE, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 16'hFEDC, 4'd4, 3'd1, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_len", 32'(len_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);

    // Basic packing and partial flush
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      chk("tbl_valid", 32'(valid_o), 32'(tbl[i].e_valid));
      chk("tbl_data", 32'(data_o), 32'(tbl[i].e_data));
      chk("tbl_len", 32'(len_o), 32'(tbl[i].e_len));
      chk("tbl_level", 32'(level_o), 32'(tbl[i].e_level));
      chk("tbl_ovf", 32'(overflow_o), 32'(tbl[i].e_ovf));
    end

    // Overflow: 20 nibbles into a stalled FIFO, then drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 4'(i), 1'b0, 1'b0);
      if (i == 15) begin
        chk("ovf_full_level", 32'(level_o), 32'd4);
        chk("ovf_not_yet", 32'(overflow_o), 32'd0);
      end
    end
    chk("ovf_level", 32'(level_o), 32'd4);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    drain_exp[0] = 16'h3210;
    drain_exp[1] = 16'h7654;
    drain_exp[2] = 16'hBA98;
    drain_exp[3] = 16'hFEDC;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(data_o), 32'(drain_exp[i]));
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(valid_o), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO with a pop on the same edge as a new push
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    chk("fullpop_pre_level", 32'(level_o), 32'd4);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 5), 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b0, 1'b1);
    chk("fullpop_level", 32'(level_o), 32'd4);
    chk("fullpop_ovf", 32'(overflow_o), 32'd0);

    // Flush coinciding with the last nibble, then flush with nothing pending
    do_reset();
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h4, 1'b1, 1'b0);
    chk("flush4_level", 32'(level_o), 32'd1);
    chk("flush4_len", 32'(len_o), 32'd4);
    chk("flush4_data", 32'(data_o), 32'h4321);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    chk("flush_idle_level", 32'(level_o), 32'd1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    chk("flush4_one_word", 32'(valid_o), 32'd0);

    // Asynchronous reset mid-word with three words queued
    do_reset();
    for (int i = 0; i < 14; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    chk("arst_pre_level", 32'(level_o), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'd0);
    chk("arst_len", 32'(len_o), 32'd0);
    chk("arst_level", 32'(level_o), 32'd0);
    chk("arst_ovf", 32'(overflow_o), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b1, 4'h6, 1'b0, 1'b0);
    cycle(1'b1, 4'h7, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b0, 1'b0);
    chk("arst_after_data", 32'(data_o), 32'h8765);
    chk("arst_after_len", 32'(len_o), 32'd4);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
